comb_bist_ctrl: RTL and testbench
=================================

Name: comb_bist_ctrl

Overview:
Built-in self-test sequencer for the team's generated combinational benchmark netlists (13-input, 23-output class).
- Generates pseudo-random input patterns with a Galois LFSR and drives them into the netlist.
- Waits a programmable settle time per pattern, then compacts the netlist outputs into a Galois MISR.
- At end of run, compares the signature against a golden value and reports pass/fail.
- Sits between the test-control register block and the netlist under test.

Parameters:
IN_W, 13, netlist input width / LFSR width
OUT_W, 23, netlist output width / MISR width
PAT_CNT, 256, number of LFSR patterns per run (>=1)
SETTLE, 2, cycles each pattern is held before capture (>=1)
LFSR_POLY, 13'h001B, LFSR feedback mask; bit i = coefficient of x^i, x^IN_W implicit (x^13+x^4+x^3+x+1)
MISR_POLY, 23'h040001, MISR feedback mask, same encoding (x^23+x^18+1)
SEED, 13'h0001, LFSR load value (nonzero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, sampled in IDLE only
abort  in  1  terminate run, no result
golden_sig  in  OUT_W  expected signature, sampled in COMPARE
dut_out  in  OUT_W  netlist outputs
dut_in  out  IN_W  netlist inputs (registered)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is valid
pass  out  1  signature == golden_sig; held until next start
signature  out  OUT_W  MISR contents
pat_idx  out  $clog2(PAT_CNT+1)  index of the pattern currently applied

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in, signature, pat_idx, busy, done, pass all 0.
- Step function: next = (r<<1) ^ (r[W-1] ? POLY : 0).
  - LFSR: lfsr <= step(lfsr).
  - MISR: misr <= step(misr) ^ dut_out.
- IDLE: dut_in=0.
  - start=1 and abort=0 -> SEED.
  - start and abort asserted together -> stay in IDLE.
- SEED (1 cycle): lfsr<=SEED, misr<=0, pat_idx<=0, settle_cnt<=0, pass<=0 -> APPLY.
- APPLY: dut_in=lfsr; settle_cnt increments each cycle; when settle_cnt==SETTLE-1 -> CAPTURE.
- CAPTURE (1 cycle):
  - MISR updates with dut_out; LFSR steps; settle_cnt<=0.
  - If pat_idx==last pattern -> COMPARE; else pat_idx++ and -> APPLY.
- COMPARE (1 cycle): pass<=(misr==golden_sig); done=1 -> IDLE.
- Each pattern occupies SETTLE+1 cycles. Start accepted at cycle 0 -> done at cycle 1+PAT_CNT*(SETTLE+1)+1.
- abort=1 in any non-IDLE state -> IDLE next cycle:
  - no done pulse; pass=0; dut_in=0.
  - signature keeps its partial value until the next SEED.
- start while busy: ignored. A start pulse must not be queued.
- LFSR never reaches 0 when SEED!=0. pat_idx does not wrap within a run.

Optional Feature:
BIST_ALL_ZERO_PAT_EN.
- Defined: after the PAT_CNT LFSR patterns, one extra pattern dut_in=0 is applied (SETTLE+1 cycles) and captured before COMPARE. Total patterns = PAT_CNT+1; pat_idx reaches PAT_CNT.
- Undefined: exactly PAT_CNT patterns; the all-zero vector is never applied.

Decomposition:
- Package comb_bist_pkg: state enum (IDLE, SEED, APPLY, CAPTURE, COMPARE), default polynomial and seed constants, galois_step function.
- Sub-module bist_galois_reg:
  - parameters W, POLY.
  - inputs load, load_val, en, din.
  - instantiated twice: LFSR with din=0, MISR with din=dut_out.

Test Plan:
1. Reset: assert rst_n=0 mid-APPLY -> busy=0, done=0, pass=0, dut_in=0, signature=0 immediately, without waiting for a clock edge.
2. PAT_CNT=4, SETTLE=1, SEED=1, dut_out=0, golden=0:
   - dut_in = 0x0001, 0x0002, 0x0004, 0x0008, each held 2 cycles.
   - done at cycle 10 after start; signature=0; pass=1.
3. PAT_CNT=2, SETTLE=1, dut_out=23'h1:
   - signature=0x000003.
   - golden=3 -> pass=1; rerun with golden=2 -> pass=0.
4. Abort during pattern 2 of scenario 2 -> busy=0 next cycle, no done pulse, pass=0. A following start reproduces signature 0 and pass=1.
5. Pulse start while busy -> run length and signature unchanged. start and abort together in IDLE -> busy stays 0.
6. BIST_ALL_ZERO_PAT_EN defined, scenario 3 settings:
   - third pattern dut_in=0.
   - signature=0x000007.
   - done at cycle 1+3*2+1=8.

Source files
------------

// File: rtl/comb_bist_pkg.sv
// Shared types and helpers for the combinational-netlist BIST sequencer.
package comb_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_APPLY,
    S_CAPTURE,
    S_COMPARE
  } state_e;

  localparam logic [12:0] DEF_LFSR_POLY = 13'h001B;
  localparam logic [22:0] DEF_MISR_POLY = 23'h040001;
  localparam logic [12:0] DEF_SEED      = 13'h0001;

  // One Galois shift of a w-bit register (w <= 64); x^w is implicit in poly.
  function automatic logic [63:0] galois_step(input logic [63:0] r, input logic [63:0] poly,
                                              input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((r << 1) ^ (r[w-1] ? poly : 64'd0)) & mask;
  endfunction

endpackage

// File: rtl/comb_bist_galois_reg.sv
// Galois shift register: LFSR when din is tied to zero, MISR when fed with responses.
module bist_galois_reg
  import comb_bist_pkg::*;
#(
  parameter int           W    = 13,
  parameter logic [W-1:0] POLY = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (load)    r_d = load_val;
    else if (en) r_d = W'(galois_step(64'(r_q), 64'(POLY), W)) ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= r_d;
  end

  assign q = r_q;

endmodule

// File: rtl/comb_bist_ctrl.sv
// BIST sequencer: LFSR patterns -> netlist -> MISR -> golden compare.
// Define BIST_ALL_ZERO_PAT_EN to append one all-zero pattern after the LFSR patterns.
module comb_bist_ctrl
  import comb_bist_pkg::*;
#(
  parameter int              IN_W      = 13,
  parameter int              OUT_W     = 23,
  parameter int              PAT_CNT   = 256,
  parameter int              SETTLE    = 2,
  parameter logic [IN_W-1:0]  LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [OUT_W-1:0] MISR_POLY = DEF_MISR_POLY,
  parameter logic [IN_W-1:0]  SEED      = DEF_SEED
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [OUT_W-1:0]           golden_sig,
  input  logic [OUT_W-1:0]           dut_out,
  output logic [IN_W-1:0]            dut_in,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [OUT_W-1:0]           signature,
  output logic [$clog2(PAT_CNT+1)-1:0] pat_idx
);

  localparam int PI_W = $clog2(PAT_CNT + 1);
  localparam int SC_W = $clog2(SETTLE + 1);
`ifdef BIST_ALL_ZERO_PAT_EN
  localparam int LAST = PAT_CNT;
`else
  localparam int LAST = PAT_CNT - 1;
`endif

  state_e            state_q, state_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [PI_W-1:0]   pat_q, pat_d;
  logic              pass_q, pass_d, done_q, done_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d;
  logic              lfsr_load, lfsr_en, misr_load, misr_en, zero_pat;
  logic [IN_W-1:0]   lfsr_q;
  logic [OUT_W-1:0]  misr_q;

  bist_galois_reg #(.W(IN_W), .POLY(LFSR_POLY)) u_lfsr (
    .clk(clk), .rst_n(rst_n), .load(lfsr_load), .load_val(SEED),
    .en(lfsr_en), .din('0), .q(lfsr_q)
  );

  bist_galois_reg #(.W(OUT_W), .POLY(MISR_POLY)) u_misr (
    .clk(clk), .rst_n(rst_n), .load(misr_load), .load_val('0),
    .en(misr_en), .din(dut_out), .q(misr_q)
  );

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    pat_d     = pat_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    // Abort wins over every in-run action, including the final compare.
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start && !abort) state_d = S_SEED;
        S_SEED: begin
          lfsr_load = 1'b1;
          misr_load = 1'b1;
          pat_d     = '0;
          settle_d  = '0;
          pass_d    = 1'b0;
          state_d   = S_APPLY;
        end
        S_APPLY: begin
          settle_d = settle_q + SC_W'(1);
          if (settle_q == SC_W'(SETTLE - 1)) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          misr_en  = 1'b1;
          lfsr_en  = 1'b1;
          settle_d = '0;
          if (pat_q == PI_W'(LAST)) state_d = S_COMPARE;
          else begin
            pat_d   = pat_q + PI_W'(1);
            state_d = S_APPLY;
          end
        end
        S_COMPARE: begin
          pass_d  = (misr_q == golden_sig);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

`ifdef BIST_ALL_ZERO_PAT_EN
  assign zero_pat = (pat_d == PI_W'(PAT_CNT));
`else
  assign zero_pat = 1'b0;
`endif

  // dut_in mirrors the LFSR value the register will hold next, so it is a clean flop output.
  always_comb begin
    dut_in_d = '0;
    if (state_d == S_APPLY || state_d == S_CAPTURE) begin
      if (state_q == S_SEED)         dut_in_d = SEED;
      else if (state_q == S_CAPTURE) dut_in_d = IN_W'(galois_step(64'(lfsr_q), 64'(LFSR_POLY), IN_W));
      else                           dut_in_d = dut_in_q;
      if (zero_pat) dut_in_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      pat_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      dut_in_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      pat_q    <= pat_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      dut_in_q <= dut_in_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = misr_q;
  assign pat_idx   = pat_q;

endmodule

// File: tb/tb_comb_bist_ctrl.sv
// Self-checking bench for comb_bist_ctrl: three configurations, directed and randomized runs.
module tb_comb_bist_ctrl;

`ifdef BIST_ALL_ZERO_PAT_EN
  localparam int ZP = 1;
`else
  localparam int ZP = 0;
`endif
  localparam int unsigned LPOLY = 32'h001B;
  localparam int unsigned MPOLY = 32'h040001;
  localparam int unsigned SEEDV = 32'h0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start_v = '0, abort_v = '0;
  logic [2:0] busy_v, done_v, pass_v;
  logic [22:0] golden = '0, cval = '0, K1 = '0, K2 = '0;
  bit uc = 1'b1;
  logic [2:0][12:0] din_v;
  logic [2:0][22:0] sig_v, dout_v;
  logic [2:0] pidx0;
  logic [1:0] pidx1;
  logic [8:0] pidx2;
  int n_chk = 0, n_fail = 0;
  logic [12:0] pats[$];
  logic [22:0] sigs[$];

  always #5 clk = ~clk;

  // Stand-in netlist: a keyed scramble of the applied vector.
  function automatic logic [22:0] netf(input logic [12:0] x);
    return (23'({10'd0, x}) * K1) ^ K2 ^ {x, 10'd0};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_net
    assign dout_v[g] = uc ? cval : netf(din_v[g]);
  end

  comb_bist_ctrl #(.PAT_CNT(4), .SETTLE(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .golden_sig(golden),
    .dut_out(dout_v[0]), .dut_in(din_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .signature(sig_v[0]), .pat_idx(pidx0));
  comb_bist_ctrl #(.PAT_CNT(2), .SETTLE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .golden_sig(golden),
    .dut_out(dout_v[1]), .dut_in(din_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .signature(sig_v[1]), .pat_idx(pidx1));
  comb_bist_ctrl ud (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .golden_sig(golden),
    .dut_out(dout_v[2]), .dut_in(din_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .signature(sig_v[2]), .pat_idx(pidx2));

  function automatic logic [63:0] obs_pidx(input int k);
    case (k)
      0:       return 64'(pidx0);
      1:       return 64'(pidx1);
      default: return 64'(pidx2);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: pattern list and cumulative signature after each capture.
  task automatic build_model(input int n);
    int unsigned l, m;
    logic [12:0] x;
    pats.delete();
    sigs.delete();
    l = SEEDV;
    m = 0;
    for (int p = 0; p < n + ZP; p++) begin
      x = (p < n) ? 13'(l) : 13'd0;
      pats.push_back(x);
      m = ((m * 2) % (1 << 23)) ^ ((m >= (1 << 22)) ? MPOLY : 32'd0) ^ 32'(uc ? cval : netf(x));
      sigs.push_back(23'(m));
      l = ((l * 2) % (1 << 13)) ^ ((l >= (1 << 12)) ? LPOLY : 32'd0);
    end
  endtask

  // gmode: 0 = use gold, 1 = golden equals model, 2 = golden off by one bit.
  task automatic run(input int k, input int n, input int s, input int gmode, input logic [22:0] gold,
                     input int abort_at, input int extra_at, input string tag);
    int cyc, lim, np, cap;
    bit seen;
    logic [22:0] part;
    build_model(n);
    np = n + ZP;
    case (gmode)
      1:       golden = sigs[np-1];
      2:       golden = sigs[np-1] ^ (23'd1 << $urandom_range(22, 0));
      default: golden = gold;
    endcase
    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
    cyc = 0;
    seen = 1'b0;
    chk({tag, "/busy_at_seed"}, 64'(busy_v[k]), 64'd1);
    lim = np * (s + 1) + 8;
    while (cyc < lim && !seen) begin
      if (cyc == abort_at) abort_v[k] = 1'b1;
      if (cyc == extra_at) start_v[k] = 1'b1;
      @(negedge clk);
      cyc++;
      abort_v[k] = 1'b0;
      start_v[k] = 1'b0;
      if (done_v[k]) seen = 1'b1;
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        cap = (abort_at >= 2 + s) ? (abort_at - 2 - s) / (s + 1) + 1 : 0;
        part = (cap == 0) ? 23'd0 : sigs[cap-1];
        chk({tag, "/abort_busy"}, 64'(busy_v[k]), 64'd0);
        chk({tag, "/abort_pass"}, 64'(pass_v[k]), 64'd0);
        chk({tag, "/abort_din"}, 64'(din_v[k]), 64'd0);
        chk({tag, "/abort_sig"}, 64'(sig_v[k]), 64'(part));
      end
      if ((abort_at < 0 || cyc <= abort_at) && cyc >= 1 && cyc <= np * (s + 1)) begin
        chk({tag, "/din"}, 64'(din_v[k]), 64'(pats[(cyc-1)/(s+1)]));
        chk({tag, "/pat_idx"}, obs_pidx(k), 64'((cyc - 1) / (s + 1)));
      end
    end
    if (abort_at >= 0) begin
      chk({tag, "/no_done"}, 64'(seen), 64'd0);
    end else begin
      chk({tag, "/done_cycle"}, 64'(cyc), 64'(np * (s + 1) + 2));
      chk({tag, "/sig"}, 64'(sig_v[k]), 64'(sigs[np-1]));
      chk({tag, "/pass"}, 64'(pass_v[k]), 64'(sigs[np-1] == golden));
      chk({tag, "/busy_end"}, 64'(busy_v[k]), 64'd0);
      chk({tag, "/din_end"}, 64'(din_v[k]), 64'd0);
      @(negedge clk);
      chk({tag, "/done_pulse"}, 64'(done_v[k]), 64'd0);
      chk({tag, "/pass_hold"}, 64'(pass_v[k]), 64'(sigs[np-1] == golden));
    end
  endtask

  initial begin
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("reset/busy", 64'(busy_v[k]), 64'd0);
      chk("reset/done", 64'(done_v[k]), 64'd0);
      chk("reset/pass", 64'(pass_v[k]), 64'd0);
      chk("reset/din", 64'(din_v[k]), 64'd0);
      chk("reset/sig", 64'(sig_v[k]), 64'd0);
      chk("reset/pidx", obs_pidx(k), 64'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    uc = 1'b1; cval = 23'd0;
    run(0, 4, 1, 0, 23'd0, -1, -1, "s2_zero");
    cval = 23'd1;
    run(1, 2, 1, 0, 23'd3, -1, -1, "s3_gold3");
    run(1, 2, 1, 0, 23'd2, -1, -1, "s3_gold2");
    run(1, 2, 1, 0, 23'd3, 4, -1, "abort_partial");

    cval = 23'd0;
    run(0, 4, 1, 0, 23'd0, 3, -1, "abort_s2");
    run(0, 4, 1, 0, 23'd0, -1, -1, "post_abort");
    run(0, 4, 1, 0, 23'd0, -1, 3, "start_busy");

    @(negedge clk); start_v[0] = 1'b1; abort_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("idle_start_abort/busy", 64'(busy_v[0]), 64'd0);
    @(negedge clk);
    chk("idle_start_abort/busy2", 64'(busy_v[0]), 64'd0);

    uc = 1'b0;
    for (int r = 0; r < 3; r++) begin
      K1 = 23'($urandom) | 23'd1;
      K2 = 23'($urandom);
      run(0, 4, 1, 1, 23'd0, -1, -1, "rand4_match");
      run(2, 256, 2, (r == 1) ? 2 : 1, 23'd0, -1, -1, "rand256");
    end
    run(1, 2, 1, 2, 23'd0, -1, -1, "rand2_miss");

    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst/busy", 64'(busy_v[0]), 64'd0);
    chk("async_rst/done", 64'(done_v[0]), 64'd0);
    chk("async_rst/pass", 64'(pass_v[0]), 64'd0);
    chk("async_rst/din", 64'(din_v[0]), 64'd0);
    chk("async_rst/sig", 64'(sig_v[0]), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run(0, 4, 1, 1, 23'd0, -1, -1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
